// File: rtl/exe_div_unit_if.sv
// Pipeline <-> divider bundle: operand/control inputs from ID/EXE and the
// stall/result signals returned to the pipeline.
interface exe_div_unit_if #(
    parameter int DATA_W = 32
);
    logic              div_start;
    logic              div_signed;
    logic [DATA_W-1:0] div_src1;
    logic [DATA_W-1:0] div_src2;
    logic              flush;
    logic              stallreq_div;
    logic              div_ready;
    logic [DATA_W-1:0] div_hi;
    logic [DATA_W-1:0] div_lo;

    modport master (
        output div_start, div_signed, div_src1, div_src2, flush,
        input  stallreq_div, div_ready, div_hi, div_lo
    );

    modport slave (
        input  div_start, div_signed, div_src1, div_src2, flush,
        output stallreq_div, div_ready, div_hi, div_lo
    );
endinterface

// File: rtl/exe_div_unit.sv
// Multi-cycle restoring radix-2 divider for MIPS DIV/DIVU (quotient->LO, remainder->HI).
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module exe_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic          cpu_clk_50M,
    input  logic          cpu_rst,
    exe_div_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvsr;
    logic              q_sign;
    logic              r_sign;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic [DATA_W-1:0] abs1;
    logic [DATA_W-1:0] abs2;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] rem_step;
    logic [DATA_W-1:0] quo_step;
    logic [DATA_W-1:0] lo_fin;
    logic [DATA_W-1:0] hi_fin;
    logic              early;

    always_comb begin
        abs1 = (bus.div_signed && bus.div_src1[DATA_W-1]) ? -bus.div_src1 : bus.div_src1;
        abs2 = (bus.div_signed && bus.div_src2[DATA_W-1]) ? -bus.div_src2 : bus.div_src2;

        // Borrow out of the (DATA_W+1)-bit subtract doubles as the rem >= divisor compare.
        rem_sh = {rem, quo[DATA_W-1]};
        diff   = rem_sh - {1'b0, dvsr};
        if (!diff[DATA_W]) begin
            rem_step = diff[DATA_W-1:0];
            quo_step = {quo[DATA_W-2:0], 1'b1};
        end else begin
            rem_step = rem_sh[DATA_W-1:0];
            quo_step = {quo[DATA_W-2:0], 1'b0};
        end

        lo_fin = q_sign ? -quo_step : quo_step;
        hi_fin = r_sign ? -rem_step : rem_step;

`ifdef DIV_EARLY_OUT_EN
        early = (abs1 < abs2);
`else
        early = 1'b0;
`endif
    end

    assign bus.stallreq_div = ~cpu_rst & ~bus.flush &
                              (((state == IDLE) & bus.div_start) | (state == BUSY));
    assign bus.div_ready    = ~cpu_rst & ~bus.flush & (state == DONE);
    assign bus.div_hi       = hi_q;
    assign bus.div_lo       = lo_q;

    // Results are registered on the edge entering DONE so they are valid alongside div_ready.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            q_sign <= 1'b0;
            r_sign <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.div_start) begin
                        if (bus.div_src2 == '0) begin
                            lo_q  <= '1;
                            hi_q  <= bus.div_src1;
                            state <= DONE;
                        end else if (early) begin
                            // Sign-corrected |src1| is src1 itself; -0 is 0.
                            lo_q  <= '0;
                            hi_q  <= bus.div_src1;
                            state <= DONE;
                        end else begin
                            rem    <= '0;
                            quo    <= abs1;
                            dvsr   <= abs2;
                            q_sign <= bus.div_signed & (bus.div_src1[DATA_W-1] ^ bus.div_src2[DATA_W-1]);
                            r_sign <= bus.div_signed & bus.div_src1[DATA_W-1];
                            cnt    <= '0;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!bus.div_start) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        rem <= rem_step;
                        quo <= quo_step;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            lo_q  <= lo_fin;
                            hi_q  <= hi_fin;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: directed table, flush/cancel/reset sequences,
// and randomized operations against an arithmetic reference model.
module tb_exe_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    always #5 clk = ~clk;

    exe_div_unit_if #(.DATA_W(32)) bus ();

    exe_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .cpu_clk_50M(clk),
        .cpu_rst    (rst),
        .bus        (bus)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division with MIPS divide-by-zero convention.
    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, ma, mb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            lat = 1;
        end else begin
            q   = 32'(sa / sb);
            r   = 32'(sa % sb);
            lat = (ma < mb) ? EO_LAT : 33;
        end
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo,
                          input logic [31:0] ehi, input int elat);
        int lat;
        bit stall_ok;
        next_cycle();
        bus.div_start  = 1'b1;
        bus.div_signed = sgn;
        bus.div_src1   = a;
        bus.div_src2   = b;
        bus.flush      = 1'b0;
        #1;
        lat      = -1;
        stall_ok = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #2;
            end
            if (bus.div_ready === 1'b1) begin
                lat = c;
                if (bus.stallreq_div !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (bus.stallreq_div !== 1'b1) stall_ok = 1'b0;
        end
        chk({name, " latency"}, 32'(lat), 32'(elat));
        chk({name, " lo"}, bus.div_lo, elo);
        chk({name, " hi"}, bus.div_hi, ehi);
        chk({name, " stallreq"}, {31'd0, stall_ok}, 32'd1);
    endtask

    task automatic watch_no_ready(input string name, input int ncyc);
        int pulses;
        pulses = 0;
        for (int c = 0; c < ncyc; c++) begin
            next_cycle();
            #1;
            if (bus.div_ready === 1'b1) pulses++;
        end
        chk({name, " ready pulses"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, r;
        int lat;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vecs[3] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1};
        vecs[4] = '{1'b1, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8,  1};
        vecs[5] = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          EO_LAT};
        vecs[6] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};

        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.div_src1   = 32'd100;
        bus.div_src2   = 32'd7;
        bus.flush      = 1'b0;
        #2;
        chk("reset lo", bus.div_lo, 32'd0);
        chk("reset hi", bus.div_hi, 32'd0);
        chk("reset ready", {31'd0, bus.div_ready}, 32'd0);
        chk("reset stallreq", {31'd0, bus.stallreq_div}, 32'd0);
        bus.div_start = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                   vecs[i].lo, vecs[i].hi, vecs[i].lat);

        // Flush at cycle 10 of a DIVU; results must keep the last vector's values.
        next_cycle();
        bus.div_start = 1'b1; bus.div_signed = 1'b0;
        bus.div_src1 = 32'd1000; bus.div_src2 = 32'd3;
        for (int c = 1; c < 10; c++) next_cycle();
        next_cycle();
        bus.flush = 1'b1;
        #1;
        chk("flush stallreq", {31'd0, bus.stallreq_div}, 32'd0);
        chk("flush ready", {31'd0, bus.div_ready}, 32'd0);
        next_cycle();
        bus.flush = 1'b0;
        bus.div_start = 1'b0;
        #1;
        chk("post-flush idle stallreq", {31'd0, bus.stallreq_div}, 32'd0);
        watch_no_ready("flush", 40);
        chk("flush lo kept", bus.div_lo, 32'hFFFF_FFFD);
        chk("flush hi kept", bus.div_hi, 32'd1);

        // Dropping div_start while busy cancels without a result.
        next_cycle();
        bus.div_start = 1'b1; bus.div_signed = 1'b0;
        bus.div_src1 = 32'd1000; bus.div_src2 = 32'd3;
        for (int c = 1; c < 5; c++) next_cycle();
        next_cycle();
        bus.div_start = 1'b0;
        watch_no_ready("cancel", 40);
        chk("cancel lo kept", bus.div_lo, 32'hFFFF_FFFD);
        run_op("after-cancel", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

        // Asynchronous reset mid-BUSY: outputs clear with no clock edge.
        next_cycle();
        bus.div_start = 1'b1; bus.div_signed = 1'b0;
        bus.div_src1 = 32'd5000; bus.div_src2 = 32'd7;
        for (int c = 1; c < 5; c++) next_cycle();
        next_cycle();
        #1;
        rst = 1'b1;
        #1;
        chk("async rst lo", bus.div_lo, 32'd0);
        chk("async rst hi", bus.div_hi, 32'd0);
        chk("async rst ready", {31'd0, bus.div_ready}, 32'd0);
        chk("async rst stallreq", {31'd0, bus.stallreq_div}, 32'd0);
        next_cycle();
        bus.div_start = 1'b0;
        next_cycle();
        rst = 1'b0;

        run_op("b2b first", 1'b0, 32'd15, 32'd4, 32'd3, 32'd3, 33);
        run_op("b2b second", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        for (int i = 0; i < 40; i++) begin
            logic        sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom % 2);
            a   = $urandom;
            b   = $urandom;
            case ($urandom % 4)
                0: b = 32'd0;
                1: b = $urandom % 16;
                2: a = $urandom % 100;
                default: ;
            endcase
            model(sgn, a, b, q, r, lat);
            run_op($sformatf("rand%0d", i), sgn, a, b, q, r, lat);
        end

        next_cycle();
        bus.div_start = 1'b0;
        next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
